// File: rtl/mem_pkg.sv
// Shared definitions for the SPRAM boot sequencer and its bank muxes.
package mem_pkg;

  // Sequencer states: prime the ROM pipeline, copy the image, then share the banks.
  typedef enum logic [1:0] {
    PRIME    = 2'd0,
    COPY     = 2'd1,
    RUN_CORE = 2'd2,
    RUN_EXT  = 2'd3
  } state_e;

  // Which requester drives a bank port.
  typedef enum logic [1:0] {
    SRC_COPY = 2'd0,
    SRC_CORE = 2'd1,
    SRC_EXT  = 2'd2
  } src_e;

  localparam logic [3:0] FULL_BE = 4'hF;

  localparam int DEF_ROM_AW = 9;
  localparam int DEF_RAM_AW = 14;

endpackage

// File: rtl/bank_port_mux.sv
// Combinational source select for one SPRAM bank: boot copy, core or loader.
module bank_port_mux
  import mem_pkg::*;
#(
  parameter int AW = DEF_RAM_AW
) (
  input  src_e          sel,
  input  logic [AW-1:0] copy_addr,
  input  logic [31:0]   copy_di,
  input  logic          copy_we,
  input  logic [AW-1:0] core_addr,
  input  logic [31:0]   core_di,
  input  logic          core_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_di,
  input  logic          ext_we,
  output logic [AW-1:0] addr,
  output logic [31:0]   di,
  output logic          we
);

  // Route the selected requester; copy is the default so reset looks like PRIME.
  always_comb begin
    addr = copy_addr;
    di   = copy_di;
    we   = copy_we;
    case (sel)
      SRC_CORE: begin
        addr = core_addr;
        di   = core_di;
        we   = core_we;
      end
      SRC_EXT: begin
        addr = ext_addr;
        di   = ext_di;
        we   = ext_we;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spram_boot_sequencer.sv
// Boot-copies the ROM image into both SPRAM banks, then arbitrates the banks
// between the core (priority) and the external loader (anti-starvation timer).
module spram_boot_sequencer
  import mem_pkg::*;
#(
  parameter int ROM_AW     = DEF_ROM_AW,
  parameter int RAM_AW     = DEF_RAM_AW,
  parameter int COPY_WORDS = 512,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              reload,
  output logic              boot,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              core_req,
  input  logic [RAM_AW-1:0] core_addr0,
  input  logic [RAM_AW-1:0] core_addr1,
  input  logic [31:0]       core_di0,
  input  logic [31:0]       core_di1,
  input  logic              core_we0,
  input  logic              core_we1,
  input  logic [3:0]        core_be,
  output logic              core_stall,
  input  logic              ext_req,
  output logic              ext_gnt,
  input  logic [RAM_AW:0]   ext_addr,
  input  logic [31:0]       ext_di,
  input  logic              ext_we,
  output logic [RAM_AW-1:0] ram_addr0,
  output logic [RAM_AW-1:0] ram_addr1,
  output logic [31:0]       ram_di0,
  output logic [31:0]       ram_di1,
  output logic              ram_we0,
  output logic              ram_we1,
  output logic [3:0]        ram_be1
);

  localparam int                SW         = $clog2(STARVE_MAX + 1);
  localparam logic [ROM_AW-1:0] LAST_PTR   = ROM_AW'(COPY_WORDS - 1);
  localparam logic [ROM_AW-1:0] ROM_ONE    = ROM_AW'(1);
  localparam logic [SW-1:0]     STARVE_SAT = SW'(STARVE_MAX);
  localparam logic [SW-1:0]     STARVE_ONE = SW'(1);

  state_e            state_reg, state_next;
  logic [ROM_AW-1:0] rom_addr_reg, rom_addr_next;
  logic [ROM_AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [SW-1:0]     starve_reg, starve_next;
  logic              reload_pend_reg, reload_pend_next;
  logic              boot_reg;
  logic              take_grant;
  src_e              src_sel;

  // State, ROM/copy pointers, starvation timer and pending reload.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg       <= PRIME;
      rom_addr_reg    <= '0;
      wr_ptr_reg      <= '0;
      starve_reg      <= '0;
      reload_pend_reg <= 1'b0;
      boot_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rom_addr_reg    <= rom_addr_next;
      wr_ptr_reg      <= wr_ptr_next;
      starve_reg      <= starve_next;
      reload_pend_reg <= reload_pend_next;
      boot_reg        <= (state_next == RUN_CORE) || (state_next == RUN_EXT);
    end
  end

  // Next-state logic: copy sequencing, grant/release and reload handling.
  always_comb begin
    state_next       = state_reg;
    rom_addr_next    = rom_addr_reg;
    wr_ptr_next      = wr_ptr_reg;
    reload_pend_next = reload_pend_reg;
    take_grant       = 1'b0;
    case (state_reg)
      PRIME: begin
        // ROM word 0 is being read now; issue word 1 as the copy starts.
        state_next    = COPY;
        rom_addr_next = ROM_ONE;
        wr_ptr_next   = '0;
      end
      COPY: begin
        rom_addr_next = rom_addr_reg + ROM_ONE;
        wr_ptr_next   = wr_ptr_reg + ROM_ONE;
        if (wr_ptr_reg == LAST_PTR) begin
          state_next    = RUN_CORE;
          rom_addr_next = '0;
          wr_ptr_next   = '0;
        end
      end
      RUN_CORE: begin
        if (reload) begin
          state_next = PRIME;
        end else if (ext_req && (!core_req || (starve_reg == STARVE_SAT))) begin
          take_grant = 1'b1;
          state_next = RUN_EXT;
        end
      end
      RUN_EXT: begin
        // A reload seen while the loader owns the banks waits for the release.
        if (reload) begin
          reload_pend_next = 1'b1;
        end
        if (!ext_req) begin
          state_next       = (reload_pend_reg || reload) ? PRIME : RUN_CORE;
          reload_pend_next = 1'b0;
        end
      end
      default: state_next = PRIME;
    endcase
  end

  // Starvation timer: counts ungranted loader-request cycles, saturating.
  always_comb begin
    starve_next = starve_reg;
    if (!ext_req || ext_gnt || take_grant) begin
      starve_next = '0;
    end else if (starve_reg != STARVE_SAT) begin
      starve_next = starve_reg + STARVE_ONE;
    end
  end

  // Bank port source follows the state; PRIME/COPY both use the copy source.
  always_comb begin
    src_sel = SRC_COPY;
    if (state_reg == RUN_CORE) begin
      src_sel = SRC_CORE;
    end else if (state_reg == RUN_EXT) begin
      src_sel = SRC_EXT;
    end
  end

  assign boot       = boot_reg;
  assign rom_addr   = rom_addr_reg;
  assign ext_gnt    = (state_reg == RUN_EXT);
  assign core_stall = (state_reg != RUN_CORE) || (core_req && take_grant);
  assign ram_be1    = (state_reg == RUN_CORE) ? core_be : FULL_BE;

  // Per-bank views of the requester ports so both banks share one mux pattern.
  logic [RAM_AW-1:0] core_addr_a [2];
  logic [31:0]       core_di_a   [2];
  logic              core_we_a   [2];
  logic              ext_we_a    [2];
  logic [RAM_AW-1:0] ram_addr_a  [2];
  logic [31:0]       ram_di_a    [2];
  logic              ram_we_a    [2];
  logic [RAM_AW-1:0] copy_addr;
  logic              copy_we;

  assign copy_addr      = RAM_AW'(wr_ptr_reg);
  assign copy_we        = (state_reg == COPY);
  assign core_addr_a[0] = core_addr0;
  assign core_addr_a[1] = core_addr1;
  assign core_di_a[0]   = core_di0;
  assign core_di_a[1]   = core_di1;

  // A core write in the cycle the loader is granted is dropped; the core is
  // stalled and will repeat it, so it cannot land after the loader's writes.
  assign core_we_a[0] = core_we0 && !take_grant;
  assign core_we_a[1] = core_we1 && !take_grant;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign ext_we_a[gi] = ext_we && (ext_addr[0] == 1'(gi));

      bank_port_mux #(
        .AW (RAM_AW)
      ) u_mux (
        .sel       (src_sel),
        .copy_addr (copy_addr),
        .copy_di   (rom_data),
        .copy_we   (copy_we),
        .core_addr (core_addr_a[gi]),
        .core_di   (core_di_a[gi]),
        .core_we   (core_we_a[gi]),
        .ext_addr  (ext_addr[RAM_AW:1]),
        .ext_di    (ext_di),
        .ext_we    (ext_we_a[gi]),
        .addr      (ram_addr_a[gi]),
        .di        (ram_di_a[gi]),
        .we        (ram_we_a[gi])
      );
    end
  endgenerate

  assign ram_addr0 = ram_addr_a[0];
  assign ram_addr1 = ram_addr_a[1];
  assign ram_di0   = ram_di_a[0];
  assign ram_di1   = ram_di_a[1];
  assign ram_we0   = ram_we_a[0];
  assign ram_we1   = ram_we_a[1];

endmodule

// File: tb/tb_spram_boot_sequencer.sv
// Scoreboard bench for spram_boot_sequencer: stimulus queues expected bank
// writes, a negedge monitor pops and compares every write the DUT issues.
module tb_spram_boot_sequencer;

  localparam int ROM_AW     = 9;
  localparam int RAM_AW     = 14;
  localparam int COPY_WORDS = 512;
  localparam int STARVE_MAX = 16;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic              reload = 1'b0;
  logic              boot;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data = '0;
  logic              core_req = 1'b0;
  logic [RAM_AW-1:0] core_addr0 = '0;
  logic [RAM_AW-1:0] core_addr1 = '0;
  logic [31:0]       core_di0 = '0;
  logic [31:0]       core_di1 = '0;
  logic              core_we0 = 1'b0;
  logic              core_we1 = 1'b0;
  logic [3:0]        core_be = '0;
  logic              core_stall;
  logic              ext_req = 1'b0;
  logic              ext_gnt;
  logic [RAM_AW:0]   ext_addr = '0;
  logic [31:0]       ext_di = '0;
  logic              ext_we = 1'b0;
  logic [RAM_AW-1:0] ram_addr0, ram_addr1;
  logic [31:0]       ram_di0, ram_di1;
  logic              ram_we0, ram_we1;
  logic [3:0]        ram_be1;

  typedef struct packed {
    logic              bank;
    logic [RAM_AW-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  wr_t         sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mem0 [2**RAM_AW];
  logic [31:0] mem1 [2**RAM_AW];

  always #5 clk = ~clk;

  // Synchronous ROM model: word k holds A5000000+k, one cycle read latency.
  always @(posedge clk) rom_data <= 32'hA5000000 + 32'(rom_addr);

  spram_boot_sequencer #(
    .ROM_AW     (ROM_AW),
    .RAM_AW     (RAM_AW),
    .COPY_WORDS (COPY_WORDS),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .reload     (reload),
    .boot       (boot),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .core_req   (core_req),
    .core_addr0 (core_addr0),
    .core_addr1 (core_addr1),
    .core_di0   (core_di0),
    .core_di1   (core_di1),
    .core_we0   (core_we0),
    .core_we1   (core_we1),
    .core_be    (core_be),
    .core_stall (core_stall),
    .ext_req    (ext_req),
    .ext_gnt    (ext_gnt),
    .ext_addr   (ext_addr),
    .ext_di     (ext_di),
    .ext_we     (ext_we),
    .ram_addr0  (ram_addr0),
    .ram_addr1  (ram_addr1),
    .ram_di0    (ram_di0),
    .ram_di1    (ram_di1),
    .ram_we0    (ram_we0),
    .ram_we1    (ram_we1),
    .ram_be1    (ram_be1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic sb_pop(input logic bank, input logic [RAM_AW-1:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    wr_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_write: bank%0d addr %0d data %h be %h, none expected",
               bank, addr, data, be);
    end else begin
      e = sb.pop_front();
      if (e.bank !== bank || e.addr !== addr || e.data !== data || e.be !== be) begin
        n_fail++;
        $display("FAIL write: got bank%0d addr %0d data %h be %h, expected bank%0d addr %0d data %h be %h",
                 bank, addr, data, be, e.bank, e.addr, e.data, e.be);
      end else begin
        $display("WR   bank%0d addr %0d data %h be %h", bank, addr, data, be);
      end
    end
    // SPRAM model so the final bank contents can be inspected.
    if (bank == 1'b0) begin
      mem0[addr] = data;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem1[addr][8*i +: 8] = data[8*i +: 8];
      end
    end
  endtask

  // Monitor: every bank write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ram_we0) sb_pop(1'b0, ram_addr0, ram_di0, 4'hF);
    if (ram_we1) sb_pop(1'b1, ram_addr1, ram_di1, ram_be1);
  end

  task automatic push_copy(input int nwords);
    for (int k = 0; k < nwords; k++) begin
      for (int b = 0; b < 2; b++) begin
        sb.push_back(wr_t'{bank: b[0], addr: RAM_AW'(k), data: 32'hA5000000 + 32'(k), be: 4'hF});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until boot is seen high; 0 means it never rose.
  task automatic wait_boot(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= COPY_WORDS + 40; i++) begin
      tick();
      if (boot) begin
        n = i;
        break;
      end
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_boot"}, 32'(boot), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_core_stall"}, 32'(core_stall), 32'd1);
    check({tag, "_ext_gnt"}, 32'(ext_gnt), 32'd0);
    check({tag, "_we"}, {30'd0, ram_we1, ram_we0}, 32'd0);
    check({tag, "_be1"}, 32'(ram_be1), 32'hF);
    check({tag, "_addr"}, 32'(ram_addr0) | 32'(ram_addr1), 32'd0);
  endtask

  // Directed stimulus.
  initial begin
    int bad0, bad1;
    #2;
    check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1;

    // Copy starts; abort it with reset right after word 200 is written.
    push_copy(201);
    resetb = 1'b1;
    repeat (201) @(posedge clk);
    @(negedge clk);
    #1;
    resetb = 1'b0;
    #1;
    check_reset_values("midcopy_reset");
    check("midcopy_words_written", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    push_copy(COPY_WORDS);
    resetb = 1'b1;
    wait_boot("boot_latency_after_reset", COPY_WORDS + 1);
    check("copy_all_written", 32'(sb.size()), 32'd0);
    bad0 = 0;
    bad1 = 0;
    for (int k = 0; k < COPY_WORDS; k++) begin
      if (mem0[k] !== 32'hA5000000 + 32'(k)) bad0++;
      if (mem1[k] !== 32'hA5000000 + 32'(k)) bad1++;
    end
    check("image_bank0_bad_words", 32'(bad0), 32'd0);
    check("image_bank1_bad_words", 32'(bad1), 32'd0);

    // Core byte-masked write to bank 1.
    core_req   = 1'b1;
    core_we1   = 1'b1;
    core_be    = 4'b0011;
    core_addr1 = 14'd5;
    core_addr0 = 14'd3;
    core_di1   = 32'h12345678;
    sb.push_back(wr_t'{bank: 1'b1, addr: 14'd5, data: 32'h12345678, be: 4'b0011});
    @(negedge clk);
    check("core_wr_stall", 32'(core_stall), 32'd0);
    check("core_wr_be1", 32'(ram_be1), 32'h3);
    check("core_wr_addr1", 32'(ram_addr1), 32'd5);
    tick();
    core_we1 = 1'b0;
    core_req = 1'b0;
    check("core_wr_merged", mem1[5], 32'hA5005678);

    // Loader grant with idle core, single write to bank 1 address 7.
    ext_req  = 1'b1;
    ext_we   = 1'b1;
    ext_addr = {14'd7, 1'b1};
    ext_di   = 32'hDEADBEEF;
    sb.push_back(wr_t'{bank: 1'b1, addr: 14'd7, data: 32'hDEADBEEF, be: 4'hF});
    @(negedge clk);
    check("ext_gnt_pre", 32'(ext_gnt), 32'd0);
    tick();
    check("ext_gnt_next_cycle", 32'(ext_gnt), 32'd1);
    check("ext_bank0_we", 32'(ram_we0), 32'd0);
    check("ext_stall", 32'(core_stall), 32'd1);
    tick();
    ext_req = 1'b0;
    ext_we  = 1'b0;
    @(negedge clk);
    check("ext_gnt_release_cycle", 32'(ext_gnt), 32'd1);
    tick();
    check("ext_gnt_dropped", 32'(ext_gnt), 32'd0);
    check("ext_bank1_7", mem1[7], 32'hDEADBEEF);
    check("ext_bank0_7", mem0[7], 32'hA5000007);

    // Busy core: loader grant forced by the starvation timer.
    core_req = 1'b1;
    ext_req  = 1'b1;
    begin
      int n;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (i == 15) check("starve_stall_c15", 32'(core_stall), 32'd0);
        if (i == 16) check("starve_stall_c16", 32'(core_stall), 32'd1);
        if (ext_gnt) begin
          n = i;
          break;
        end
      end
      check("starve_grant_cycle", 32'(n), 32'(STARVE_MAX + 1));
    end
    check("starve_stall_granted", 32'(core_stall), 32'd1);

    // Reload while the loader owns the banks: deferred until release.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    repeat (5) tick();
    check("reload_pending_boot", 32'(boot), 32'd1);
    check("reload_pending_gnt", 32'(ext_gnt), 32'd1);
    push_copy(COPY_WORDS);
    ext_req  = 1'b0;
    core_req = 1'b0;
    tick();
    check("reload_boot_low", 32'(boot), 32'd0);
    check("reload_gnt_low", 32'(ext_gnt), 32'd0);
    wait_boot("boot_latency_reload", COPY_WORDS + 1);
    check("reload_all_written", 32'(sb.size()), 32'd0);
    check("reload_bank1_5", mem1[5], 32'hA5000005);
    check("reload_bank1_7", mem1[7], 32'hA5000007);

    repeat (2) tick();
    check("no_stray_writes", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
